// File: rtl/pointing_uart_tx_if.sv
// Bytestream link from the pointing-device byte generator into the UART transmitter.
interface pointing_uart_tx_if;
    logic       in_write;
    logic [7:0] in_data;

    modport master (output in_write, output in_data);
    modport slave  (input  in_write, input  in_data);
endinterface

// File: rtl/pointing_uart_tx.sv
// 8N1 serializer for the pointing-device bytestream, fed through a small byte FIFO.
// rts flushes the FIFO and abandons any frame in flight.
module pointing_uart_tx #(
    parameter int CLKS_PER_BIT    = 25000,
    parameter int OC_CLKS_PER_BIT = 20000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    pointing_uart_tx_if.slave             bs,
    input  logic                          rts,
    input  logic                          overclock,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_PER = (CLKS_PER_BIT > OC_CLKS_PER_BIT) ? CLKS_PER_BIT : OC_CLKS_PER_BIT;
    localparam int CNT_W   = (MAX_PER > 2) ? $clog2(MAX_PER) : 1;

    localparam logic [CNT_W-1:0] NRM_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] OC_RELOAD  = CNT_W'(OC_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [LVL_W-1:0] LVL_ZERO   = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              overflow_r;
    logic [7:0]        shift_r;
    logic [2:0]        bit_idx_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  reload_r;
    logic              txd_r;
    logic              busy_r;

    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [7:0]        head_s;
    logic [CNT_W-1:0]  next_reload_s;

    // Pop/push/drop decisions; a pop frees a slot for a same-cycle push.
    always_comb begin
        pop_s         = 1'b0;
        push_s        = 1'b0;
        drop_s        = 1'b0;
        head_s        = mem_r[rd_ptr_r];
        next_reload_s = overclock ? OC_RELOAD : NRM_RELOAD;
        if (!rts && (level_r != LVL_ZERO) &&
            ((state_r == IDLE) || ((state_r == STOP) && (cnt_r == CNT_ZERO)))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (bs.in_write && !rts) begin
            if ((level_r != FULL_LVL) || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Byte FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            overflow_r <= 1'b0;
        end else if (rts) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bs.in_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame FSM: the period is latched at pop so overclock changes only affect later frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            shift_r   <= 8'h00;
            bit_idx_r <= 3'd0;
            cnt_r     <= CNT_ZERO;
            reload_r  <= CNT_ZERO;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else if (rts) begin
            state_r   <= IDLE;
            bit_idx_r <= 3'd0;
            cnt_r     <= CNT_ZERO;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r  <= head_s;
                        reload_r <= next_reload_s;
                        cnt_r    <= next_reload_s;
                        state_r  <= START;
                        txd_r    <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        txd_r  <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r     <= reload_r;
                        bit_idx_r <= 3'd0;
                        txd_r     <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r <= reload_r;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= shift_r >> 1;
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (pop_s) begin
                        shift_r  <= head_s;
                        reload_r <= next_reload_s;
                        cnt_r    <= next_reload_s;
                        state_r  <= START;
                        txd_r    <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        txd_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    txd_r   <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign txd        = txd_r;
    assign busy       = busy_r;
    assign fifo_level = level_r;
    assign overflow   = overflow_r;
endmodule

// File: tb/tb_pointing_uart_tx.sv
// Self-checking bench for pointing_uart_tx: logged line waveform is compared against
// frames laid out from the byte list and bit periods.
module tb_pointing_uart_tx;
    localparam int P_NRM = 16;
    localparam int P_OC  = 12;
    localparam int DEPTH = 4;

    typedef logic [7:0] byte_q_t [$];
    typedef int         int_q_t  [$];

    logic       clk;
    logic       reset_n;
    logic       rts;
    logic       overclock;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_checks;
    int n_fail;

    logic       txd_log  [$];
    logic       busy_log [$];
    logic [2:0] lvl_log  [$];

    pointing_uart_tx_if bs_if ();

    pointing_uart_tx #(
        .CLKS_PER_BIT   (P_NRM),
        .OC_CLKS_PER_BIT(P_OC),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bs        (bs_if.slave),
        .rts       (rts),
        .overclock (overclock),
        .txd       (txd),
        .busy      (busy),
        .fifo_level(fifo_level),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample after each rising edge; entry k of a window is the state after edge base+k.
    always @(posedge clk) begin
        #2;
        txd_log.push_back(txd);
        busy_log.push_back(busy);
        lvl_log.push_back(fifo_level);
    end

    // Reference: frames start one cycle after the first write, back to back,
    // each 10 bits of p cycles: start 0, data LSB first, stop 1.
    function automatic int wave_errs(input byte_q_t b, input int_q_t p, input int base, input int n);
        int   errs;
        int   start;
        int   k;
        logic et;
        logic eb;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            et    = 1'b1;
            eb    = 1'b0;
            start = 1;
            for (int f = 0; f < b.size(); f++) begin
                if (i >= start && i < start + 10 * p[f]) begin
                    k  = (i - start) / p[f];
                    eb = 1'b1;
                    if (k == 0)      et = 1'b0;
                    else if (k == 9) et = 1'b1;
                    else             et = b[f][k-1];
                end
                start = start + 10 * p[f];
            end
            if (base + i >= txd_log.size()) errs++;
            else if (txd_log[base+i] !== et || busy_log[base+i] !== eb) errs++;
        end
        return errs;
    endfunction

    function automatic int busy_count(input int base, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i < busy_log.size() && busy_log[base+i] === 1'b1) c++;
        end
        return c;
    endfunction

    task automatic write_seq(input byte_q_t b);
        for (int i = 0; i < b.size(); i++) begin
            bs_if.in_write = 1'b1;
            bs_if.in_data  = b[i];
            @(negedge clk);
        end
        bs_if.in_write = 1'b0;
        bs_if.in_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        byte_q_t b;
        int_q_t  p;
        int      base;
        int      e;
        int      bc;
        for (int it = 0; it < 3; it++) begin
            b    = '{((it == 0) ? 8'hCA : 8'($urandom))};
            p    = '{P_NRM};
            base = txd_log.size();
            write_seq(b);
            repeat (175) @(negedge clk);
            n_checks++;
            if (txd_log[base] !== 1'b1 || txd_log[base+1] !== 1'b0) begin
                n_fail++; $display("FAIL single_latency got %b%b want 10", txd_log[base], txd_log[base+1]);
            end
            e = wave_errs(b, p, base, 172);
            n_checks++; if (e !== 0) begin n_fail++; $display("FAIL single_wave byte %h got %0d bad cycles want 0", b[0], e); end
            bc = busy_count(base, 172);
            n_checks++; if (bc !== 160) begin n_fail++; $display("FAIL single_busy_len got %0d want 160", bc); end
            n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_level got %0d want 0", fifo_level); end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t    b;
        int_q_t     p;
        int         base;
        int         e;
        int         bc;
        logic [2:0] pk;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) b = '{8'hC0, 8'h82, 8'h85};
            else         b = '{8'($urandom), 8'($urandom), 8'($urandom)};
            p    = '{P_NRM, P_NRM, P_NRM};
            base = txd_log.size();
            write_seq(b);
            repeat (490) @(negedge clk);
            e = wave_errs(b, p, base, 490);
            n_checks++; if (e !== 0) begin n_fail++; $display("FAIL b2b_wave got %0d bad cycles want 0", e); end
            bc = busy_count(base, 490);
            n_checks++; if (bc !== 480) begin n_fail++; $display("FAIL b2b_busy_len got %0d want 480", bc); end
            pk = 3'd0;
            for (int i = 0; i < 490; i++) if (lvl_log[base+i] > pk) pk = lvl_log[base+i];
            n_checks++; if (pk !== 3'd2) begin n_fail++; $display("FAIL b2b_level_peak got %0d want 2", pk); end
        end
    endtask

    task automatic test_rts_with_write();
        byte_q_t b;
        b = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        write_seq(b);
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL rtsw_full_level got %0d want 4", fifo_level); end
        rts = 1'b1; bs_if.in_write = 1'b1; bs_if.in_data = 8'($urandom);
        @(negedge clk);
        rts = 1'b0; bs_if.in_write = 1'b0;
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rtsw_level got %0d want 0", fifo_level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rtsw_overflow got %b want 0", overflow); end
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rtsw_idle got txd %b busy %b want 1 0", txd, busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rtsw_stays_idle got level %0d busy %b want 0 0", fifo_level, busy); end
    endtask

    task automatic test_overflow();
        byte_q_t b;
        byte_q_t sent;
        int_q_t  p;
        int      base;
        int      e;
        b    = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        sent = b[0:4];
        p    = '{P_NRM, P_NRM, P_NRM, P_NRM, P_NRM};
        base = txd_log.size();
        write_seq(b);
        n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        repeat (812) @(negedge clk);
        e = wave_errs(sent, p, base, 815);
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL ovf_wave got %0d bad cycles want 0", e); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL ovf_drain_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_rts_abort();
        byte_q_t b;
        int_q_t  p;
        int      base;
        int      e;
        int      bad;
        b    = '{8'($urandom), 8'($urandom), 8'($urandom)};
        p    = '{P_NRM};
        base = txd_log.size();
        write_seq(b);
        repeat (68) @(negedge clk);
        rts = 1'b1;
        @(negedge clk);
        rts = 1'b0;
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rts_idle got txd %b busy %b want 1 0", txd, busy); end
        n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rts_level got %0d want 0", fifo_level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rts_overflow_kept got %b want 1", overflow); end
        repeat (40) @(negedge clk);
        e = wave_errs('{b[0]}, p, base, 71);
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rts_pre_abort_wave got %0d bad cycles want 0", e); end
        bad = 0;
        for (int i = 71; i < 110; i++) if (txd_log[base+i] !== 1'b1 || busy_log[base+i] !== 1'b0) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rts_abandon got %0d active cycles want 0", bad); end
        base = txd_log.size();
        write_seq('{8'h81});
        repeat (175) @(negedge clk);
        e = wave_errs('{8'h81}, p, base, 172);
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rts_after_wave got %0d bad cycles want 0", e); end
    endtask

    task automatic test_overclock();
        byte_q_t b;
        int_q_t  p;
        int      base;
        int      m;
        int      e;
        int      bc;
        overclock = 1'b0;
        b    = '{8'($urandom), 8'($urandom)};
        p    = '{P_NRM, P_OC};
        m    = $urandom_range(120, 20);
        base = txd_log.size();
        write_seq(b);
        repeat (m) @(negedge clk);
        overclock = 1'b1;
        repeat (292 - m) @(negedge clk);
        e = wave_errs(b, p, base, 290);
        n_checks++; if (e !== 0) begin n_fail++; $display("FAIL oc_wave got %0d bad cycles want 0", e); end
        bc = busy_count(base, 290);
        n_checks++; if (bc !== 280) begin n_fail++; $display("FAIL oc_busy_len got %0d want 280", bc); end
        overclock = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        int bad;
        write_seq('{8'($urandom)});
        repeat (149) @(negedge clk);
        n_checks++; if (overflow !== 1'b1 || txd !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre got ovf %b txd %b busy %b want 1 1 1", overflow, txd, busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_line got txd %b busy %b want 1 0", txd, busy); end
        n_checks++; if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_state got ovf %b level %0d want 0 0", overflow, fifo_level);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        base = txd_log.size();
        repeat (30) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 29; i++) if (txd_log[base+i] !== 1'b1 || busy_log[base+i] !== 1'b0) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rstmid_idle got %0d active cycles want 0", bad); end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        rts            = 1'b0;
        overclock      = 1'b0;
        bs_if.in_write = 1'b0;
        bs_if.in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_rts_with_write();
        test_overflow();
        test_rts_abort();
        test_overclock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
